// File: rtl/native_arb_pkg.sv
// native_arb_pkg: shared state type, timeout read value and the wrap-around
// index helper used by the native bus arbiter and its rr_arbiter.
package native_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT     = 2'd2,
        RESP_PAD = 2'd3
    } arb_state_e;

    // Read data returned on a watchdog abort; sliced to the data width.
    localparam logic [63:0] RDATA_TIMEOUT = '1;

    function automatic int unsigned rr_wrap(
        input int unsigned base,
        input int unsigned off,
        input int unsigned n
    );
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant. Searches req starting one past
// last and wraps. Ports: req (requests), last (previous winner),
// gnt (one-hot grant, zero if no request), gnt_idx (binary winner index).
module rr_arbiter
    import native_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = rr_wrap(int'(unsigned'(last)), k, NREQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/native_bus_arb.sv
// native_bus_arb: round-robin share of one native register port among NREQ
// requesters, one transaction at a time, response routed to the owner.
// Ports: req_* / rsp_* requester side, m_* downstream bridge side.
// Optional watchdog abort: define NATIVE_ARB_TIMEOUT_EN (limit TIMEOUT_CYC).
module native_bus_arb
    import native_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int W           = 32,
    parameter int A           = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [NREQ-1:0] req_we_i,
    input  logic [NREQ*A-1:0] req_addr_i,
    input  logic [NREQ*W-1:0] req_wdata_i,
    output logic [NREQ-1:0] req_ready_o,
    output logic [NREQ-1:0] rsp_valid_o,
    output logic [W-1:0]    rsp_rdata_o,
    output logic            rsp_err_o,
    output logic            m_valid_o,
    input  logic            m_ready_i,
    output logic            m_we_o,
    output logic [A-1:0]    m_addr_o,
    output logic [W-1:0]    m_wdata_o,
    input  logic            m_done_i,
    input  logic [W-1:0]    m_rdata_i,
    input  logic            m_err_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] owner_oh;
    logic            accept;
    logic            done_now;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req     (req_valid_i),
        .last    (last_grant),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign req_ready_o = (rst_n_i && state == IDLE) ? gnt : '0;
    assign accept      = |(req_valid_i & req_ready_o);
    assign owner_oh    = NREQ'(1) << owner;

    // Completion either straight from ISSUE (ready and done together) or in WAIT.
    assign done_now = (state == ISSUE && m_ready_i && m_done_i)
                   || (state == WAIT && m_done_i);

`ifdef NATIVE_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    assign tmo_hit = (state == ISSUE || state == WAIT)
                  && (tmo_cnt == TW'(TIMEOUT_CYC - 1))
                  && !done_now;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            last_grant  <= IW'(NREQ - 1);
            owner       <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            m_valid_o   <= 1'b0;
            m_we_o      <= 1'b0;
            m_addr_o    <= '0;
            m_wdata_o   <= '0;
`ifdef NATIVE_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            rsp_valid_o <= '0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        m_we_o    <= req_we_i[gnt_idx];
                        m_addr_o  <= req_addr_i[gnt_idx*A +: A];
                        m_wdata_o <= req_wdata_i[gnt_idx*W +: W];
                        owner     <= gnt_idx;
                        m_valid_o <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_ready_i) begin
                        m_valid_o <= 1'b0;
                        state     <= m_done_i ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (m_done_i) state <= IDLE;
                end
                RESP_PAD: state <= IDLE;
            endcase

            if (done_now) begin
                rsp_rdata_o <= m_we_o ? '0 : m_rdata_i;
                rsp_err_o   <= m_err_i;
                rsp_valid_o <= owner_oh;
                last_grant  <= owner;
            end

`ifdef NATIVE_ARB_TIMEOUT_EN
            if (accept) begin
                tmo_cnt <= '0;
            end else if (tmo_hit) begin
                m_valid_o   <= 1'b0;
                rsp_err_o   <= 1'b1;
                rsp_rdata_o <= RDATA_TIMEOUT[W-1:0];
                rsp_valid_o <= owner_oh;
                last_grant  <= owner;
                state       <= IDLE;
            end else if (state == ISSUE || state == WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: doc/native_bus_arb.md
Name: native_bus_arb

Overview:
- Round-robin arbiter that shares one native register-access port (the native-to-AXI-Lite bridge front end) between NREQ requesters, e.g. the UART command decoder and the HDMI timing/config sequencer.
- Accepts one read or write at a time and forwards it downstream.
- Waits for completion, then routes read data and error status back to the owning requester.
- Sits between the requesters and the bridge; no transaction overlap.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 32, data width.
- A, 4, address width.
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset.
- req_valid_i  in  NREQ  per-requester request valid; held until accepted.
- req_we_i  in  NREQ  1 = write, 0 = read.
- req_addr_i  in  NREQ*A  flattened addresses; requester i at [i*A +: A].
- req_wdata_i  in  NREQ*W  flattened write data.
- req_ready_o  out  NREQ  one-hot accept, combinational.
- rsp_valid_o  out  NREQ  one-hot, one-cycle completion pulse.
- rsp_rdata_o  out  W  read data of the last completed transaction.
- rsp_err_o  out  1  error flag of the last completed transaction.
- m_valid_o  out  1  downstream command valid.
- m_ready_i  in  1  downstream command accept.
- m_we_o  out  1  downstream write enable.
- m_addr_o  out  A  downstream address.
- m_wdata_o  out  W  downstream write data.
- m_done_i  in  1  downstream completion pulse.
- m_rdata_i  in  W  completion read data.
- m_err_i  in  1  completion error (bridge resp != OKAY).

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-low, on rst_n_i.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - last_grant = NREQ-1, so requester 0 wins the first arbitration.
- IDLE:
  - grant = first asserted req_valid_i index, searching from last_grant+1 and wrapping modulo NREQ.
  - req_ready_o[grant] = 1 combinationally, only in IDLE.
  - On req_valid_i[g] && req_ready_o[g]: latch we/addr/wdata into m_* registers, store owner g, set m_valid_o=1, go to ISSUE.
- ISSUE:
  - m_valid_o and all m_* outputs held stable until m_ready_i.
  - m_ready_i && !m_done_i: drop m_valid_o, go to WAIT.
  - m_ready_i && m_done_i in the same cycle: complete directly, as in WAIT.
- WAIT:
  - On m_done_i: rsp_rdata_o <= m_rdata_i for reads, 0 for writes; rsp_err_o <= m_err_i.
  - Next cycle: rsp_valid_o[owner] = 1 for exactly one cycle; last_grant <= owner; state returns to IDLE.
- Latency:
  - Accept to m_valid_o: 1 cycle.
  - m_done_i to rsp_valid_o: 1 cycle.
  - A new accept is possible in the same cycle rsp_valid_o pulses.
- Fairness: a requester that has just completed has lowest priority in the next arbitration. No requester waits more than NREQ-1 transactions.
- Ignored inputs: m_done_i in IDLE or in ISSUE without m_ready_i is ignored (spurious).
- Requester-side changes: req_valid_i dropping before accept is legal and cancels nothing. Inputs are sampled only at accept.
- Reset mid-transaction: immediate return to IDLE, m_valid_o=0, no rsp_valid_o pulse. A late m_done_i is ignored.
- Width rules: rsp_rdata_o and rsp_err_o are shared by all requesters and hold until the next completion. A requester must qualify them with its own rsp_valid_o bit.

Optional Feature:
- Macro: NATIVE_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on accept and increments each cycle in ISSUE/WAIT.
  - On reaching TIMEOUT_CYC-1: m_valid_o <= 0, rsp_err_o <= 1, rsp_rdata_o <= all ones, rsp_valid_o[owner] pulses, state returns to IDLE.
  - The first m_done_i arriving afterwards in IDLE is ignored.
- Without the macro: no counter logic; the arbiter waits indefinitely in ISSUE/WAIT.

Decomposition:
- Package native_arb_pkg holds:
  - State enum: IDLE, ISSUE, WAIT, RESP_PAD (reserved).
  - Constant RDATA_TIMEOUT = all ones.
  - Helper function for the wrap-around index.
- Sub-module rr_arbiter (NREQ): combinational one-hot grant from the request vector and the last_grant pointer. Reusable by the DMA/config blocks.

Test Plan:
- Single read: req 0 reads addr 4, downstream m_ready_i after 2 cycles, m_done_i after 5 with rdata 0x1234_5678, err 0 -> rsp_valid_o=01 one cycle after done, rsp_rdata_o=0x1234_5678, rsp_err_o=0.
- Simultaneous requests: req_valid_i=11 held, all writes -> grants alternate 0,1,0,1 over 4 transactions. rsp_rdata_o=0 for each write.
- Same-cycle ready and done: m_ready_i and m_done_i both high in ISSUE -> response pulses the next cycle with no WAIT visit. The next accept lands in that same response cycle.
- Error and reset: write with m_err_i=1 -> rsp_err_o=1. Then assert rst_n_i=0 in WAIT -> all outputs 0, later m_done_i produces no rsp_valid_o, and requester 0 wins the next arbitration.
- Timeout (macro defined, TIMEOUT_CYC=16): m_ready_i=1, m_done_i never -> rsp_valid_o pulses 16 cycles after accept, with rsp_err_o=1 and rsp_rdata_o=0xFFFF_FFFF. The next request is accepted normally.
- Spurious done: m_done_i pulse in IDLE -> no rsp_valid_o, rsp_rdata_o unchanged.
